// File: rtl/vr_stim_pkg.sv
// Shared types and constants for the valid/ready stimulus source.
// The generator step function lives here so the datagen stays a plain register.
package vr_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_INC  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
  function automatic logic [31:0] gen_next(input mode_t mode, input logic [31:0] cur);
    if (mode == MODE_LFSR) begin
      return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
    end
    return cur + 32'd1;
  endfunction

endpackage

// File: rtl/vr_stim_datagen.sv
// 32-bit data generator: reloads the seed on load, steps only on advance.
import vr_stim_pkg::*;

module vr_stim_datagen #(
  parameter logic [31:0] P_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  mode_t       mode,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= P_SEED;
    end else if (load) begin
      state <= P_SEED;
    end else if (advance) begin
      state <= gen_next(mode, state);
    end
  end

endmodule

// File: rtl/vr_stim_source.sv
// Valid/ready stimulus source: emits cfg_count words with cfg_gap idle cycles
// between them, plus a free-running throttled ready for a downstream sink.
import vr_stim_pkg::*;

module vr_stim_source #(
  parameter int          P_DWIDTH = 32,
  parameter logic [31:0] P_SEED   = 32'h0000_0001
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         cfg_count,
  input  logic [3:0]          cfg_gap,
  input  logic                cfg_mode,
  input  logic [7:0]          cfg_rdy_pat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [P_DWIDTH-1:0] out_data,
  output logic                snk_ready,
  output logic                busy,
  output logic                done,
  output logic [15:0]         xfer_count,
  output state_t              dbg_state
);

  if (P_DWIDTH < 1 || P_DWIDTH > 32) begin : g_bad_dwidth
    $error("vr_stim_source: P_DWIDTH must be within 1..32");
  end
  if (P_SEED == 32'h0) begin : g_bad_seed
    $error("vr_stim_source: P_SEED must be non-zero");
  end

  // Handshake: a word transfers on every rising edge where out_valid && out_ready;
  // while out_valid is high it stays high and out_data holds until that edge.

  state_t      state;
  logic [15:0] count_q;
  logic [3:0]  gap_q;
  logic [3:0]  gap_cnt;
  mode_t       mode_q;
  logic [2:0]  rdy_idx;
  logic [31:0] gen_state;
  logic        fire;
  logic        load;

  assign fire      = out_valid & out_ready;
  assign load      = start & (state == ST_IDLE);
  assign out_data  = gen_state[P_DWIDTH-1:0];
  assign dbg_state = state;

  vr_stim_datagen #(
    .P_SEED (P_SEED)
  ) u_datagen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (fire),
    .mode    (mode_q),
    .state   (gen_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      xfer_count <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      mode_q     <= MODE_INC;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            count_q    <= cfg_count;
            gap_q      <= cfg_gap;
            mode_q     <= mode_t'(cfg_mode);
            xfer_count <= '0;
            busy       <= 1'b1;
            if (cfg_count != 16'd0) begin
              state     <= ST_SEND;
              out_valid <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (fire) begin
            xfer_count <= xfer_count + 16'd1;
            if (xfer_count + 16'd1 == count_q) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (gap_q != 4'd0) begin
              state     <= ST_GAP;
              out_valid <= 1'b0;
              gap_cnt   <= gap_q;
            end
          end
        end
        ST_GAP: begin
          // gap_cnt starts at cfg_gap, so valid stays low for exactly that many cycles
          if (gap_cnt == 4'd1) begin
            state     <= ST_SEND;
            out_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sink ready rotation runs regardless of the sequence FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_idx <= 3'd0;
    end else begin
      rdy_idx <= rdy_idx + 3'd1;
    end
  end

  assign snk_ready = cfg_rdy_pat[rdy_idx];

endmodule

// File: tb/tb_vr_stim_source.sv
// Scoreboard bench for vr_stim_source: two instances (seed 1 and seed FFFF_FFFE)
// share all inputs; a reference model fills expected queues that a monitor drains.
import vr_stim_pkg::*;

module tb_vr_stim_source;

  localparam logic [31:0] SEED_A = 32'h0000_0001;
  localparam logic [31:0] SEED_B = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_count = '0;
  logic [3:0]  cfg_gap = '0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_rdy_pat = 8'b0000_0101;
  logic        out_ready;
  logic        rnd_ready = 1'b0;
  logic        ready_set = 1'b1;
  int          ready_mode = 0;

  logic        a_out_valid, a_snk_ready, a_busy, a_done;
  logic [31:0] a_out_data;
  logic [15:0] a_xfer_count;
  state_t      a_dbg_state;
  logic        b_out_valid, b_snk_ready, b_busy, b_done;
  logic [31:0] b_out_data;
  logic [15:0] b_xfer_count;
  state_t      b_dbg_state;

  assign out_ready = (ready_mode == 1) ? rnd_ready : ready_set;

  vr_stim_source #(.P_DWIDTH(32), .P_SEED(SEED_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_rdy_pat(cfg_rdy_pat), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .snk_ready(a_snk_ready), .busy(a_busy),
    .done(a_done), .xfer_count(a_xfer_count), .dbg_state(a_dbg_state)
  );

  vr_stim_source #(.P_DWIDTH(32), .P_SEED(SEED_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_rdy_pat(cfg_rdy_pat), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .snk_ready(b_snk_ready), .busy(b_busy),
    .done(b_done), .xfer_count(b_xfer_count), .dbg_state(b_dbg_state)
  );

  // ---------------- clock / reset-domain bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int ridx = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ridx <= 0;
    else        ridx <= (ridx + 1) % 8;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  int started_cnt = 0, abort_cnt = 0, done_cnt = 0;
  int exp_count = 0, exp_gap = 0, start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next value: increment modulo 2^32, or Galois LFSR stepping right.
  function automatic logic [31:0] model_next(input logic md, input logic [31:0] s);
    logic [31:0] r;
    logic        lsb;
    if (!md) return s + 32'd1;
    lsb = s[0];
    r = s >> 1;
    if (lsb) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // ---------------- monitor ----------------
  bit          seen_fire = 1'b0;
  int          low_run = 0;
  int          last_fire_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] ea, eb;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q_a.delete();
      exp_q_b.delete();
      seen_fire  = 1'b0;
      low_run    = 0;
      prev_stall = 1'b0;
    end else if (clk == 1'b0) begin
      check("snk_ready_a", 32'(a_snk_ready), 32'(cfg_rdy_pat[ridx]));
      check("snk_ready_b", 32'(b_snk_ready), 32'(cfg_rdy_pat[ridx]));
      check("valid_lockstep", 32'(b_out_valid), 32'(a_out_valid));
      if (prev_stall) begin
        check("stall_valid", 32'(a_out_valid), 32'd1);
        check("stall_data", a_out_data, prev_data);
      end
      prev_stall = a_out_valid && !out_ready;
      prev_data  = a_out_data;
      if (a_out_valid) begin
        check("valid_expected",
              32'((started_cnt != done_cnt + abort_cnt) && exp_q_a.size() != 0), 32'd1);
        if (out_ready && exp_q_a.size() != 0 && exp_q_b.size() != 0) begin
          ea = exp_q_a.pop_front();
          eb = exp_q_b.pop_front();
          check("data_a", a_out_data, ea);
          check("data_b", b_out_data, eb);
          if (seen_fire) check("gap_len", 32'(low_run), 32'(exp_gap));
          seen_fire     = 1'b1;
          low_run       = 0;
          last_fire_cyc = cyc;
        end
      end else if (a_busy && !a_done && seen_fire) begin
        low_run++;
      end
      if (a_done) begin
        check("done_expected", 32'(started_cnt != done_cnt + abort_cnt), 32'd1);
        check("done_timing", 32'(cyc - ((exp_count == 0) ? start_cyc : last_fire_cyc)), 32'd1);
        check("xfer_count_done", 32'(a_xfer_count), 32'(exp_count));
        check("queue_drained", 32'(exp_q_a.size()), 32'd0);
        seen_fire = 1'b0;
        low_run   = 0;
        done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [15:0] cnt, input logic [3:0] gap, input logic md);
    logic [31:0] sa, sb;
    sa = SEED_A;
    sb = SEED_B;
    @(posedge clk); #1;
    cfg_count = cnt; cfg_gap = gap; cfg_mode = md; start = 1'b1;
    exp_count = cnt; exp_gap = gap; start_cyc = cyc;
    for (int i = 0; i < cnt; i++) begin
      exp_q_a.push_back(sa);
      exp_q_b.push_back(sb);
      sa = model_next(md, sa);
      sb = model_next(md, sb);
    end
    started_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    // Configuration must have been latched; scramble it.
    cfg_count = 16'($urandom); cfg_gap = 4'($urandom); cfg_mode = 1'($urandom);
  endtask

  task automatic run_seq(input logic [15:0] cnt, input logic [3:0] gap, input logic md,
                         input bit poke, input bit rand_pat);
    int  prev_done;
    bit  got;
    bit  can;
    prev_done = done_cnt;
    got = 1'b0;
    issue_start(cnt, gap, md);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (done_cnt != prev_done) begin
        got = 1'b1;
        break;
      end
      can = a_busy && !a_done;
      @(posedge clk); #1;
      start = poke && can && ($urandom_range(0, 4) == 0);
      cfg_count = 16'($urandom); cfg_gap = 4'($urandom); cfg_mode = 1'($urandom);
      if (rand_pat) cfg_rdy_pat = 8'($urandom);
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    @(negedge clk); #1;
    check("idle_busy", 32'(a_busy), 32'd0);
    check("idle_hold_count", 32'(a_xfer_count), 32'(cnt));
  endtask

  task automatic check_reset_values();
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_data_a", a_out_data, SEED_A);
    check("rst_data_b", b_out_data, SEED_B);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_xfer_count", 32'(a_xfer_count), 32'd0);
    check("rst_state", 32'(a_dbg_state), 32'(ST_IDLE));
    check("rst_snk_ready", 32'(a_snk_ready), 32'(cfg_rdy_pat[0]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    #20 rst_n = 1'b1;

    // Incrementing back-to-back, then a short run through the 32-bit wrap on instance b.
    ready_mode = 0; ready_set = 1'b1;
    run_seq(16'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    run_seq(16'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    // Stall for 5 cycles on the first word, with 2-cycle gaps.
    ready_set = 1'b0;
    fork
      run_seq(16'd3, 4'd2, 1'b0, 1'b0, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (a_out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_first_valid", 32'(seen), 32'd1);
        repeat (5) @(posedge clk);
        #1 ready_set = 1'b1;
      end
    join

    // LFSR, empty sequence.
    run_seq(16'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    run_seq(16'd0, 4'd3, 1'b0, 1'b0, 1'b0);

    // Abort a 10-word sequence after 5 transfers.
    issue_start(16'd10, 4'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_xfer_count == 16'd5) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_reached_5", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    abort_cnt++;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(started_cnt - abort_cnt));
    run_seq(16'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    // Randomized sequences with throttled ready, live pattern changes and ignored starts.
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      run_seq(16'($urandom_range(0, 12)),
              ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    ready_mode = 0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
